// File: rtl/controlador_vendas_if.sv
// Coin acceptor / selector / dispenser bundle for controlador_vendas.
// master = panel and acceptor side, slave = the controller.
interface controlador_vendas_if #(
  parameter int N_PRODUTOS = 4,
  parameter int CREDITO_W  = 5
);
  localparam int SEL_W = $clog2(N_PRODUTOS);

  logic                  cent25;
  logic                  cent50;
  logic                  real1;
  logic [SEL_W-1:0]      selecao;
  logic                  confirma;
  logic                  cancela;
  logic [N_PRODUTOS-1:0] estoque_vazio;
  logic [CREDITO_W-1:0]  credito;
  logic [N_PRODUTOS-1:0] libera_produto;
  logic [CREDITO_W-1:0]  troco;
  logic                  troco_valido;
  logic                  rejeita_moeda;
  logic                  erro_venda;

  modport master (
    output cent25, cent50, real1, selecao, confirma, cancela, estoque_vazio,
    input  credito, libera_produto, troco, troco_valido, rejeita_moeda, erro_venda
  );

  modport slave (
    input  cent25, cent50, real1, selecao, confirma, cancela, estoque_vazio,
    output credito, libera_produto, troco, troco_valido, rejeita_moeda, erro_venda
  );
endinterface

// File: rtl/controlador_vendas.sv
// Vending controller: coin credit in 25c units, per-product prices, change and refund.
// Optional macro CREDITO_BCD_EN adds credito_bcd (credit in centavos as 3 BCD digits).
module controlador_vendas #(
  parameter int N_PRODUTOS     = 4,
  parameter int CREDITO_W      = 5,
  parameter int CREDITO_MAX    = 16,
  parameter logic [N_PRODUTOS*CREDITO_W-1:0] PRECOS = {N_PRODUTOS{CREDITO_W'(6)}},
  parameter int TIMEOUT_CICLOS = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  controlador_vendas_if.slave bus
`ifdef CREDITO_BCD_EN
  ,output logic [11:0]        credito_bcd
`endif
);
  localparam int SEL_W = $clog2(N_PRODUTOS);
  localparam int TW    = $clog2(TIMEOUT_CICLOS + 1);

  typedef enum logic [1:0] {OCIOSO, ACUMULA, VENDE, TROCO} estado_t;

  estado_t               estado, estado_d;
  logic [CREDITO_W-1:0]  credito_q, credito_d, troco_q, troco_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [N_PRODUTOS-1:0] libera_q, libera_d;
  logic                  tv_q, tv_d, rej_q, rej_d, erro_q, erro_d;

  logic                  coin_any, coin_extra, coin_ok, timeout;
  logic [2:0]            coin_val;
  logic [CREDITO_W:0]    coin_sum;
  logic [CREDITO_W-1:0]  preco_sel;
  logic                  sel_valido, vazio_sel, venda_ok;

  function automatic logic [CREDITO_W-1:0] preco_de(input logic [SEL_W-1:0] s);
    preco_de = '0;
    for (int i = 0; i < N_PRODUTOS; i++)
      if (s == SEL_W'(i)) preco_de = PRECOS[i*CREDITO_W +: CREDITO_W];
  endfunction

  function automatic logic [N_PRODUTOS-1:0] onehot(input logic [SEL_W-1:0] s);
    onehot = '0;
    for (int i = 0; i < N_PRODUTOS; i++)
      if (s == SEL_W'(i)) onehot[i] = 1'b1;
  endfunction

  // Out-of-range selections never match the loop, so they read as invalid.
  always_comb begin
    sel_valido = 1'b0;
    vazio_sel  = 1'b1;
    for (int i = 0; i < N_PRODUTOS; i++)
      if (bus.selecao == SEL_W'(i)) begin
        sel_valido = 1'b1;
        vazio_sel  = bus.estoque_vazio[i];
      end
  end

  assign preco_sel = preco_de(bus.selecao);
  assign venda_ok  = sel_valido && !vazio_sel && (credito_q >= preco_sel);
  assign timeout   = (timer_q == TW'(TIMEOUT_CICLOS - 1));

  // Only the highest-value coin of a simultaneous group is considered.
  assign coin_any   = bus.cent25 | bus.cent50 | bus.real1;
  assign coin_extra = bus.real1 ? (bus.cent50 | bus.cent25) : (bus.cent50 & bus.cent25);
  assign coin_val   = bus.real1 ? 3'd4 : bus.cent50 ? 3'd2 : bus.cent25 ? 3'd1 : 3'd0;
  assign coin_sum   = {1'b0, credito_q} + (CREDITO_W+1)'(coin_val);
  assign coin_ok    = (coin_sum <= (CREDITO_W+1)'(CREDITO_MAX));

  always_comb begin
    estado_d  = estado;
    credito_d = credito_q;
    troco_d   = troco_q;
    timer_d   = timer_q;
    sel_d     = sel_q;
    libera_d  = '0;
    tv_d      = 1'b0;
    rej_d     = 1'b0;
    erro_d    = 1'b0;
    case (estado)
      OCIOSO: begin
        timer_d = '0;
        if (bus.confirma) erro_d = 1'b1;
        if (coin_any) begin
          rej_d = coin_extra | !coin_ok;
          if (coin_ok) begin
            credito_d = coin_sum[CREDITO_W-1:0];
            estado_d  = ACUMULA;
          end
        end
      end
      ACUMULA: begin
        timer_d = timer_q + 1'b1;
        if (bus.cancela) begin
          estado_d = TROCO;
          rej_d    = coin_any;
        end else if (bus.confirma) begin
          timer_d = '0;
          rej_d   = coin_any;
          if (venda_ok) begin
            estado_d = VENDE;
            sel_d    = bus.selecao;
          end else begin
            erro_d = 1'b1;
          end
        end else if (timeout) begin
          estado_d = TROCO;
          rej_d    = coin_any;
        end else if (coin_any) begin
          rej_d = coin_extra | !coin_ok;
          if (coin_ok) begin
            credito_d = coin_sum[CREDITO_W-1:0];
            timer_d   = '0;
          end
        end
      end
      VENDE: begin
        rej_d     = coin_any;
        libera_d  = onehot(sel_q);
        credito_d = credito_q - preco_de(sel_q);
        estado_d  = TROCO;
      end
      TROCO: begin
        rej_d     = coin_any;
        troco_d   = credito_q;
        tv_d      = 1'b1;
        credito_d = '0;
        timer_d   = '0;
        estado_d  = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) estado <= OCIOSO;
    else        estado <= estado_d;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      credito_q <= '0;
      troco_q   <= '0;
      timer_q   <= '0;
      sel_q     <= '0;
      libera_q  <= '0;
      tv_q      <= 1'b0;
      rej_q     <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      credito_q <= credito_d;
      troco_q   <= troco_d;
      timer_q   <= timer_d;
      sel_q     <= sel_d;
      libera_q  <= libera_d;
      tv_q      <= tv_d;
      rej_q     <= rej_d;
      erro_q    <= erro_d;
    end

  assign bus.credito        = credito_q;
  assign bus.troco          = troco_q;
  assign bus.libera_produto = libera_q;
  assign bus.troco_valido   = tv_q;
  assign bus.rejeita_moeda  = rej_q;
  assign bus.erro_venda     = erro_q;

`ifdef CREDITO_BCD_EN
  // Units of 25c: integer reais = credit/4, centavos from the two low bits.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) credito_bcd <= '0;
    else begin
      credito_bcd[11:8] <= 4'(credito_q >> 2);
      case (credito_q[1:0])
        2'd0:    credito_bcd[7:0] <= 8'h00;
        2'd1:    credito_bcd[7:0] <= 8'h25;
        2'd2:    credito_bcd[7:0] <= 8'h50;
        default: credito_bcd[7:0] <= 8'h75;
      endcase
    end
`endif
endmodule

// File: tb/tb_controlador_vendas.sv
// Directed bench for controlador_vendas: cycle table plus timeout and reset sequences.
module tb_controlador_vendas;
  localparam int N = 4, W = 5, TMO = 20;
  localparam logic [N*W-1:0] PR = {5'd10, 5'd6, 5'd6, 5'd3};

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  controlador_vendas_if #(.N_PRODUTOS(N), .CREDITO_W(W)) bus();
`ifdef CREDITO_BCD_EN
  logic [11:0] credito_bcd;
`endif

  controlador_vendas #(.N_PRODUTOS(N), .CREDITO_W(W), .CREDITO_MAX(16),
                       .PRECOS(PR), .TIMEOUT_CICLOS(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
`ifdef CREDITO_BCD_EN
    , .credito_bcd(credito_bcd)
`endif
  );

  typedef struct {
    int r1, c50, c25, conf, canc, sel, est;
    int cred, lib, tv, troco, rej, err;
  } vec_t;

  vec_t tbl[$];
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int r1, input int c50, input int c25, input int conf,
                       input int canc, input int sel, input int est);
    bus.real1 = 1'(r1); bus.cent50 = 1'(c50); bus.cent25 = 1'(c25);
    bus.confirma = 1'(conf); bus.cancela = 1'(canc);
    bus.selecao = 2'(sel); bus.estoque_vazio = 4'(est);
  endtask

  initial begin
    //               r1 c50 c25 cf cn sel est   cred lib tv trc rej err
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0,      4, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 0,      6, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 0,      7, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0,      7, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 1, 0,      7, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0,      1, 2, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0,      0, 0, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0});
    // exact sale, zero change
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0,      4, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 0,      6, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 1, 0,      6, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0,      0, 2, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0,      0, 0, 1, 0, 0, 0});
    // sold out product, then a cheaper product
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0,      4, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 2, 4,      4, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 4,      4, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0,      1, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0,      0, 0, 1, 1, 0, 0});
    // insufficient credit, then cancel
    tbl.push_back('{0, 0, 1, 0, 0, 0, 0,      1, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 3, 0,      1, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 0,      1, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0,      0, 0, 1, 1, 0, 0});
    // credit ceiling
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0,      4, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0,      8, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0,     12, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 0,     14, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 0,     15, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0,     15, 0, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 0,     16, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 0,     16, 0, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 0,     16, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0,      0, 0, 1, 16, 0, 0});
    // simultaneous coins
    tbl.push_back('{1, 0, 1, 0, 0, 0, 0,      4, 0, 0, 0, 1, 0});
    tbl.push_back('{0, 1, 1, 0, 0, 0, 0,      6, 0, 0, 0, 1, 0});
    // cancela beats confirma
    tbl.push_back('{0, 0, 0, 1, 1, 1, 0,      6, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0,      0, 0, 1, 6, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0});
    // confirma while idle
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0,      0, 0, 0, 0, 0, 1});
    // coins during VENDE and TROCO
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0,      4, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0,      8, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 1, 0,      8, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 0,      2, 2, 0, 0, 1, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 0,      0, 0, 1, 2, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0});
    // confirma beats coin
    tbl.push_back('{0, 0, 1, 0, 0, 0, 0,      1, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 1, 0, 3, 0,      1, 0, 0, 0, 1, 1});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 0,      1, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0,      0, 0, 1, 1, 0, 0});

    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_credito", int'(bus.credito), 0);
    chk("rst_troco", int'(bus.troco), 0);
    chk("rst_pulses", int'({bus.libera_produto, bus.troco_valido, bus.rejeita_moeda, bus.erro_venda}), 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].r1, tbl[i].c50, tbl[i].c25, tbl[i].conf, tbl[i].canc, tbl[i].sel, tbl[i].est);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_credito", i), int'(bus.credito), tbl[i].cred);
      chk($sformatf("v%0d_libera", i), int'(bus.libera_produto), tbl[i].lib);
      chk($sformatf("v%0d_troco_valido", i), int'(bus.troco_valido), tbl[i].tv);
      if (tbl[i].tv != 0) chk($sformatf("v%0d_troco", i), int'(bus.troco), tbl[i].troco);
      chk($sformatf("v%0d_rejeita", i), int'(bus.rejeita_moeda), tbl[i].rej);
      chk($sformatf("v%0d_erro", i), int'(bus.erro_venda), tbl[i].err);
    end
    drive(0, 0, 0, 0, 0, 0, 0);

    // Inactivity timeout with credit 3: refund arrives TMO+1 edges after the last coin edge.
    begin
      int seen;
      seen = 0;
      drive(0, 1, 0, 0, 0, 0, 0); @(posedge clk); #1;
      drive(0, 0, 1, 0, 0, 0, 0); @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("tmo_credito", int'(bus.credito), 3);
      for (int k = 1; k <= TMO + 10 && seen == 0; k++) begin
        @(posedge clk); #1;
        if (bus.troco_valido) seen = k;
      end
      chk("tmo_latency", seen, TMO + 1);
      chk("tmo_troco", int'(bus.troco), 3);
      chk("tmo_credito_after", int'(bus.credito), 0);
    end

    // Reset during VENDE clears everything and nothing is dispensed afterwards.
    begin
      int pulses;
      pulses = 0;
      drive(1, 0, 0, 0, 0, 0, 0); @(posedge clk); #1;
      drive(1, 0, 0, 0, 0, 0, 0); @(posedge clk); #1;
      drive(0, 0, 0, 1, 0, 1, 0); @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("rv_credito_pre", int'(bus.credito), 8);
      rst_n = 1'b0;
      #1;
      chk("rv_credito", int'(bus.credito), 0);
      chk("rv_pulses", int'({bus.libera_produto, bus.troco_valido, bus.rejeita_moeda, bus.erro_venda}), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) begin
        @(posedge clk); #1;
        if (bus.libera_produto != 0 || bus.troco_valido) pulses++;
      end
      chk("rv_no_pulses", pulses, 0);
      chk("rv_credito_after", int'(bus.credito), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
